// File: rtl/tlb_pkg.sv
// Shared constants, op encodings and payload types for the TLB maintenance engine.
package tlb_pkg;

  localparam int unsigned TLBNUM  = 16;
  localparam int unsigned IDXW    = $clog2(TLBNUM);
  localparam int unsigned ENTRY_W = 89;
  localparam int unsigned OPW     = 3;
  localparam int unsigned INVOPW  = 5;
  localparam int unsigned VPPNW   = 19;
  localparam int unsigned ASIDW   = 10;

  // Field offsets inside {e,vppn,ps,asid,g,ppn0,plv0,mat0,d0,v0,ppn1,plv1,mat1,d1,v1}
  localparam int unsigned E_BIT    = 88;
  localparam int unsigned VPPN_LSB = 69;
  localparam int unsigned ASID_LSB = 53;

  localparam logic [INVOPW-1:0] INVOP_MAX = INVOPW'(6);

  typedef enum logic [OPW-1:0] {
    OP_SRCH = 3'd0,
    OP_RD   = 3'd1,
    OP_WR   = 3'd2,
    OP_FILL = 3'd3,
    OP_INV  = 3'd4
  } tlb_op_e;

  typedef struct packed {
    tlb_op_e              op;
    logic [INVOPW-1:0]    invop;
    logic [ASIDW-1:0]     inv_asid;
    logic [VPPNW-1:0]     inv_vppn;
    logic [ENTRY_W-1:0]   entry;
    logic [IDXW-1:0]      index;
    logic [IDXW-1:0]      fill_idx;
  } op_req_t;

endpackage

// File: rtl/tlb_fill_ctr.sv
// Free-running wrapping index counter used as the TLBFILL victim pointer.
module tlb_fill_ctr
  import tlb_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  output logic [IDXW-1:0] cnt
);

  logic [IDXW-1:0] cnt_q;
  logic [IDXW-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == IDXW'(TLBNUM - 1)) ? '0 : cnt_q + IDXW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/tlb_op_engine.sv
// Executes TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB as IDLE->EXEC->RESP, one op in flight.
module tlb_op_engine
  import tlb_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [OPW-1:0]      req_op,
  input  logic [INVOPW-1:0]   req_invop,
  input  logic [ASIDW-1:0]    req_inv_asid,
  input  logic [VPPNW-1:0]    req_inv_vppn,
  input  logic [ENTRY_W-1:0]  csr_entry,
  input  logic [IDXW-1:0]     csr_index,
  output logic                done,
  output logic                ine_exc,
  output logic                csr_we,
  output logic [ENTRY_W-1:0]  csr_wb_entry,
  output logic [IDXW-1:0]     csr_wb_index,
  output logic                csr_wb_ne,
  output logic                csr_wb_is_rd,
  output logic [VPPNW-1:0]    tlb_s1_vppn,
  output logic                tlb_s1_va_bit12,
  output logic [ASIDW-1:0]    tlb_s1_asid,
  input  logic                tlb_s1_found,
  input  logic [IDXW-1:0]     tlb_s1_index,
  output logic [IDXW-1:0]     tlb_r_index,
  input  logic [ENTRY_W-1:0]  tlb_r_entry,
  output logic                tlb_we,
  output logic [IDXW-1:0]     tlb_w_index,
  output logic [ENTRY_W-1:0]  tlb_w_entry,
  output logic                tlb_invtlb_valid,
  output logic [INVOPW-1:0]   tlb_invtlb_op
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  op_req_t             op_q, op_d;
  logic [IDXW-1:0]     fill_cnt;

  logic                req_ready_q, req_ready_d;
  logic                done_q, done_d;
  logic                ine_exc_q, ine_exc_d;
  logic                csr_we_q, csr_we_d;
  logic [ENTRY_W-1:0]  csr_wb_entry_q, csr_wb_entry_d;
  logic [IDXW-1:0]     csr_wb_index_q, csr_wb_index_d;
  logic                csr_wb_ne_q, csr_wb_ne_d;
  logic                csr_wb_is_rd_q, csr_wb_is_rd_d;
  logic [VPPNW-1:0]    s1_vppn_q, s1_vppn_d;
  logic [ASIDW-1:0]    s1_asid_q, s1_asid_d;
  logic [IDXW-1:0]     r_index_q, r_index_d;
  logic                we_q, we_d;
  logic [IDXW-1:0]     w_index_q, w_index_d;
  logic [ENTRY_W-1:0]  w_entry_q, w_entry_d;
  logic                inv_valid_q, inv_valid_d;
  logic [INVOPW-1:0]   inv_op_q, inv_op_d;

  tlb_fill_ctr u_fill_ctr (
    .clk    (clk),
    .resetn (resetn),
    .cnt    (fill_cnt)
  );

  // Outputs are registered from the next state, so TLB strobes line up exactly with EXEC
  // and the RESP writeback captures the TLB's combinational answer at the EXEC edge.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    done_d         = 1'b0;
    ine_exc_d      = 1'b0;
    csr_we_d       = 1'b0;
    csr_wb_entry_d = '0;
    csr_wb_index_d = '0;
    csr_wb_ne_d    = 1'b0;
    csr_wb_is_rd_d = 1'b0;
    s1_vppn_d      = '0;
    s1_asid_d      = '0;
    r_index_d      = '0;
    we_d           = 1'b0;
    w_index_d      = '0;
    w_entry_d      = '0;
    inv_valid_d    = 1'b0;
    inv_op_d       = '0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d.op       = tlb_op_e'(req_op);
          op_d.invop    = req_invop;
          op_d.inv_asid = req_inv_asid;
          op_d.inv_vppn = req_inv_vppn;
          op_d.entry    = csr_entry;
          op_d.index    = csr_index;
          op_d.fill_idx = fill_cnt;
          state_d       = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_RESP;
        done_d  = 1'b1;
        case (op_q.op)
          OP_SRCH: begin
            csr_we_d       = 1'b1;
            csr_wb_ne_d    = ~tlb_s1_found;
            csr_wb_index_d = tlb_s1_found ? tlb_s1_index : '0;
          end
          OP_RD: begin
            csr_we_d       = 1'b1;
            csr_wb_is_rd_d = 1'b1;
            if (tlb_r_entry[E_BIT]) csr_wb_entry_d = tlb_r_entry;
            else                    csr_wb_ne_d    = 1'b1;
          end
          OP_INV:  ine_exc_d = (op_q.invop > INVOP_MAX);
          default: ;
        endcase
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_EXEC) begin
      case (op_d.op)
        OP_SRCH: begin
          s1_vppn_d = op_d.entry[VPPN_LSB +: VPPNW];
          s1_asid_d = op_d.entry[ASID_LSB +: ASIDW];
        end
        OP_RD: r_index_d = op_d.index;
        OP_WR: begin
          we_d      = 1'b1;
          w_index_d = op_d.index;
          w_entry_d = op_d.entry;
        end
        OP_FILL: begin
          we_d      = 1'b1;
          w_index_d = op_d.fill_idx;
          w_entry_d = op_d.entry;
        end
        OP_INV: begin
          if (op_d.invop <= INVOP_MAX) begin
            inv_valid_d = 1'b1;
            inv_op_d    = op_d.invop;
            s1_asid_d   = op_d.inv_asid;
            s1_vppn_d   = op_d.inv_vppn;
          end
        end
        default: ;
      endcase
    end

    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      op_q           <= '0;
      req_ready_q    <= 1'b1;
      done_q         <= 1'b0;
      ine_exc_q      <= 1'b0;
      csr_we_q       <= 1'b0;
      csr_wb_entry_q <= '0;
      csr_wb_index_q <= '0;
      csr_wb_ne_q    <= 1'b0;
      csr_wb_is_rd_q <= 1'b0;
      s1_vppn_q      <= '0;
      s1_asid_q      <= '0;
      r_index_q      <= '0;
      we_q           <= 1'b0;
      w_index_q      <= '0;
      w_entry_q      <= '0;
      inv_valid_q    <= 1'b0;
      inv_op_q       <= '0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      req_ready_q    <= req_ready_d;
      done_q         <= done_d;
      ine_exc_q      <= ine_exc_d;
      csr_we_q       <= csr_we_d;
      csr_wb_entry_q <= csr_wb_entry_d;
      csr_wb_index_q <= csr_wb_index_d;
      csr_wb_ne_q    <= csr_wb_ne_d;
      csr_wb_is_rd_q <= csr_wb_is_rd_d;
      s1_vppn_q      <= s1_vppn_d;
      s1_asid_q      <= s1_asid_d;
      r_index_q      <= r_index_d;
      we_q           <= we_d;
      w_index_q      <= w_index_d;
      w_entry_q      <= w_entry_d;
      inv_valid_q    <= inv_valid_d;
      inv_op_q       <= inv_op_d;
    end
  end

  assign req_ready        = req_ready_q;
  assign done             = done_q;
  assign ine_exc          = ine_exc_q;
  assign csr_we           = csr_we_q;
  assign csr_wb_entry     = csr_wb_entry_q;
  assign csr_wb_index     = csr_wb_index_q;
  assign csr_wb_ne        = csr_wb_ne_q;
  assign csr_wb_is_rd     = csr_wb_is_rd_q;
  assign tlb_s1_vppn      = s1_vppn_q;
  assign tlb_s1_va_bit12  = 1'b0;
  assign tlb_s1_asid      = s1_asid_q;
  assign tlb_r_index      = r_index_q;
  assign tlb_we           = we_q;
  assign tlb_w_index      = w_index_q;
  assign tlb_w_entry      = w_entry_q;
  assign tlb_invtlb_valid = inv_valid_q;
  assign tlb_invtlb_op    = inv_op_q;

endmodule

// File: tb/tb_tlb_op_engine.sv
// Self-checking bench for tlb_op_engine: behavioural TLB model plus expected-response queue.
module tb_tlb_op_engine;
  import tlb_pkg::*;

  typedef struct packed {
    logic        csr_we;
    logic        ne;
    logic        is_rd;
    logic        ine;
    logic [3:0]  idx;
    logic [88:0] entry;
  } resp_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  w_index;
    logic [88:0] w_entry;
    logic        inv_valid;
    logic [4:0]  inv_op;
    logic [18:0] s1_vppn;
    logic [9:0]  s1_asid;
    logic [3:0]  r_index;
  } exec_t;

  localparam logic [88:0] PRE9 = {1'b0, 19'h55555, 6'd12, 10'h003, 1'b0, 20'hFFFFF, 2'd3, 2'd3,
                                  1'b1, 1'b1, 20'hFFFFF, 2'd3, 2'd3, 1'b1, 1'b1};

  logic        clk, resetn, req_valid, req_ready;
  logic [2:0]  req_op;
  logic [4:0]  req_invop;
  logic [9:0]  req_inv_asid;
  logic [18:0] req_inv_vppn;
  logic [88:0] csr_entry;
  logic [3:0]  csr_index;
  logic        done, ine_exc, csr_we, csr_wb_ne, csr_wb_is_rd;
  logic [88:0] csr_wb_entry;
  logic [3:0]  csr_wb_index;
  logic [18:0] tlb_s1_vppn;
  logic        tlb_s1_va_bit12;
  logic [9:0]  tlb_s1_asid;
  logic        tlb_s1_found;
  logic [3:0]  tlb_s1_index;
  logic [3:0]  tlb_r_index;
  logic [88:0] tlb_r_entry;
  logic        tlb_we;
  logic [3:0]  tlb_w_index;
  logic [88:0] tlb_w_entry;
  logic        tlb_invtlb_valid;
  logic [4:0]  tlb_invtlb_op;

  logic [88:0] tlb_mem [16];
  logic        model_loaded = 1'b0;
  logic [3:0]  fc_model;
  resp_t       exp_q [$];
  int          n_checks = 0;
  int          n_pass   = 0;

  tlb_op_engine dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_invop(req_invop), .req_inv_asid(req_inv_asid),
    .req_inv_vppn(req_inv_vppn), .csr_entry(csr_entry), .csr_index(csr_index),
    .done(done), .ine_exc(ine_exc), .csr_we(csr_we), .csr_wb_entry(csr_wb_entry),
    .csr_wb_index(csr_wb_index), .csr_wb_ne(csr_wb_ne), .csr_wb_is_rd(csr_wb_is_rd),
    .tlb_s1_vppn(tlb_s1_vppn), .tlb_s1_va_bit12(tlb_s1_va_bit12), .tlb_s1_asid(tlb_s1_asid),
    .tlb_s1_found(tlb_s1_found), .tlb_s1_index(tlb_s1_index), .tlb_r_index(tlb_r_index),
    .tlb_r_entry(tlb_r_entry), .tlb_we(tlb_we), .tlb_w_index(tlb_w_index),
    .tlb_w_entry(tlb_w_entry), .tlb_invtlb_valid(tlb_invtlb_valid), .tlb_invtlb_op(tlb_invtlb_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [88:0] mk_entry(input logic e, input logic [18:0] vppn, input logic [9:0] asid,
                                           input logic g, input logic [19:0] ppn0, input logic [19:0] ppn1);
    return {e, vppn, 6'd12, asid, g, ppn0, 2'd0, 2'd1, 1'b1, 1'b1, ppn1, 2'd3, 2'd1, 1'b0, 1'b1};
  endfunction

  function automatic logic srch_hit(input int i, input logic [18:0] vppn, input logic [9:0] asid);
    return tlb_mem[i][88] && (tlb_mem[i][87:69] == vppn) && (tlb_mem[i][52] || (tlb_mem[i][62:53] == asid));
  endfunction

  function automatic logic inv_hit(input int i, input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vppn);
    logic g, am, vm;
    g  = tlb_mem[i][52];
    am = (tlb_mem[i][62:53] == asid);
    vm = (tlb_mem[i][87:69] == vppn);
    case (op)
      5'd0, 5'd1: return 1'b1;
      5'd2:       return g;
      5'd3:       return !g;
      5'd4:       return !g && am;
      5'd5:       return !g && am && vm;
      5'd6:       return (g || am) && vm;
      default:    return 1'b0;
    endcase
  endfunction

  // Behavioural TLB: combinational search/read, writes and invalidates on the clock edge.
  always_comb begin
    tlb_s1_found = 1'b0;
    tlb_s1_index = 4'hA;
    for (int i = 15; i >= 0; i--) begin
      if (srch_hit(i, tlb_s1_vppn, tlb_s1_asid)) begin
        tlb_s1_found = 1'b1;
        tlb_s1_index = 4'(i);
      end
    end
  end

  assign tlb_r_entry = tlb_mem[tlb_r_index];

  always @(posedge clk) begin
    if (!model_loaded) begin
      for (int i = 0; i < 16; i++) tlb_mem[i] <= '0;
      tlb_mem[9]   <= PRE9;
      model_loaded <= 1'b1;
    end else begin
      if (tlb_we) tlb_mem[tlb_w_index] <= tlb_w_entry;
      if (tlb_invtlb_valid)
        for (int i = 0; i < 16; i++)
          if (inv_hit(i, tlb_invtlb_op, tlb_s1_asid, tlb_s1_vppn)) tlb_mem[i][88] <= 1'b0;
    end
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) fc_model <= 4'd0;
    else         fc_model <= (fc_model == 4'd15) ? 4'd0 : fc_model + 4'd1;
  end

  function automatic resp_t predict(input logic [2:0] op, input logic [4:0] invop,
                                    input logic [88:0] ent, input logic [3:0] idx);
    resp_t r;
    r = '0;
    case (op)
      3'd0: begin
        r.csr_we = 1'b1;
        r.ne     = 1'b1;
        for (int i = 0; i < 16; i++)
          if (r.ne && srch_hit(i, ent[87:69], ent[62:53])) begin r.ne = 1'b0; r.idx = 4'(i); end
      end
      3'd1: begin
        r.csr_we = 1'b1;
        r.is_rd  = 1'b1;
        if (tlb_mem[idx][88]) r.entry = tlb_mem[idx];
        else                  r.ne    = 1'b1;
      end
      3'd4:    r.ine = (invop > 5'd6);
      default: ;
    endcase
    return r;
  endfunction

  // Drives one op from the current negedge; returns the EXEC snapshot, the RESP snapshot and
  // the accept-to-done latency in cycles (-1 if the op was never accepted or never completed).
  task automatic run_op(input logic [2:0] op, input logic [4:0] invop, input logic [9:0] ia,
                        input logic [18:0] iv, input logic [88:0] ent, input logic [3:0] idx,
                        output exec_t ex, output resp_t rs, output int lat);
    int wait_n;
    ex = '0; rs = '0; lat = -1; wait_n = 0;
    req_op = op; req_invop = invop; req_inv_asid = ia; req_inv_vppn = iv;
    csr_entry = ent; csr_index = idx; req_valid = 1'b1;
    while (!req_ready && wait_n < 20) begin @(negedge clk); wait_n++; end
    if (!req_ready) begin req_valid = 1'b0; return; end
    @(negedge clk);
    req_valid = 1'b0;
    ex = '{tlb_we, tlb_w_index, tlb_w_entry, tlb_invtlb_valid, tlb_invtlb_op,
           tlb_s1_vppn, tlb_s1_asid, tlb_r_index};
    for (int c = 1; c <= 6; c++) begin
      if (done) begin
        lat = c;
        rs  = '{csr_we, csr_wb_ne, csr_wb_is_rd, ine_exc, csr_wb_index, csr_wb_entry};
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_fc(input logic [3:0] target);
    int n = 0;
    while (!(fc_model == target && req_ready) && n < 40) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset();
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got=%0b exp=1", req_ready); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%0b exp=0", done); else n_pass++;
    n_checks++; if (tlb_we !== 1'b0 || tlb_invtlb_valid !== 1'b0)
      $display("FAIL reset_strobes got we=%0b inv=%0b exp=0", tlb_we, tlb_invtlb_valid); else n_pass++;
    n_checks++; if (csr_we !== 1'b0 || ine_exc !== 1'b0)
      $display("FAIL reset_csr got we=%0b ine=%0b exp=0", csr_we, ine_exc); else n_pass++;
    n_checks++; if (tlb_s1_vppn !== 19'd0 || tlb_s1_asid !== 10'd0 || tlb_w_index !== 4'd0 || tlb_s1_va_bit12 !== 1'b0)
      $display("FAIL reset_ports got vppn=%0h asid=%0h widx=%0h", tlb_s1_vppn, tlb_s1_asid, tlb_w_index); else n_pass++;
  endtask

  task automatic test_write_search();
    exec_t ex; resp_t rs, e; int lat;
    logic [88:0] e5;
    e5 = mk_entry(1'b1, 19'h12345, 10'h001, 1'b0, 20'hABCDE, 20'h13579);
    exp_q.push_back(predict(3'd2, 5'd0, e5, 4'd5));
    run_op(3'd2, 5'd0, 10'd0, 19'd0, e5, 4'd5, ex, rs, lat);
    e = exp_q.pop_front();
    n_checks++; if (lat !== 2) $display("FAIL wr_latency got=%0d exp=2", lat); else n_pass++;
    n_checks++; if (ex.we !== 1'b1 || ex.w_index !== 4'd5)
      $display("FAIL wr_strobe got we=%0b idx=%0d exp we=1 idx=5", ex.we, ex.w_index); else n_pass++;
    n_checks++; if (ex.w_entry !== e5) $display("FAIL wr_entry got=%h exp=%h", ex.w_entry, e5); else n_pass++;
    n_checks++; if (rs.csr_we !== e.csr_we) $display("FAIL wr_csr_we got=%0b exp=%0b", rs.csr_we, e.csr_we); else n_pass++;

    exp_q.push_back(predict(3'd0, 5'd0, e5, 4'd0));
    run_op(3'd0, 5'd0, 10'd0, 19'd0, e5, 4'd0, ex, rs, lat);
    e = exp_q.pop_front();
    n_checks++; if (lat !== 2) $display("FAIL srch_latency got=%0d exp=2", lat); else n_pass++;
    n_checks++; if (ex.s1_vppn !== 19'h12345 || ex.s1_asid !== 10'h001 || ex.we !== 1'b0)
      $display("FAIL srch_ports got vppn=%0h asid=%0h we=%0b", ex.s1_vppn, ex.s1_asid, ex.we); else n_pass++;
    n_checks++; if (rs !== e)
      $display("FAIL srch_hit got we=%0b ne=%0b rd=%0b idx=%0d exp we=%0b ne=%0b rd=%0b idx=%0d",
               rs.csr_we, rs.ne, rs.is_rd, rs.idx, e.csr_we, e.ne, e.is_rd, e.idx); else n_pass++;
  endtask

  task automatic test_search_miss();
    exec_t ex; resp_t rs, e; int lat;
    logic [88:0] key;
    key = mk_entry(1'b1, 19'h7FFFF, 10'h001, 1'b0, 20'd0, 20'd0);
    exp_q.push_back(predict(3'd0, 5'd0, key, 4'd0));
    run_op(3'd0, 5'd0, 10'd0, 19'd0, key, 4'd0, ex, rs, lat);
    e = exp_q.pop_front();
    n_checks++; if (rs.csr_we !== e.csr_we || rs.ne !== e.ne || rs.is_rd !== e.is_rd || rs.idx !== e.idx)
      $display("FAIL srch_miss got we=%0b ne=%0b rd=%0b idx=%0d exp we=%0b ne=%0b rd=%0b idx=%0d",
               rs.csr_we, rs.ne, rs.is_rd, rs.idx, e.csr_we, e.ne, e.is_rd, e.idx); else n_pass++;
  endtask

  task automatic test_read();
    exec_t ex; resp_t rs, e; int lat;
    logic [3:0] idxs [2];
    idxs = '{4'd5, 4'd9};
    foreach (idxs[k]) begin
      exp_q.push_back(predict(3'd1, 5'd0, '0, idxs[k]));
      run_op(3'd1, 5'd0, 10'd0, 19'd0, '0, idxs[k], ex, rs, lat);
      e = exp_q.pop_front();
      n_checks++; if (ex.r_index !== idxs[k]) $display("FAIL rd_index got=%0d exp=%0d", ex.r_index, idxs[k]); else n_pass++;
      n_checks++; if (rs.csr_we !== e.csr_we || rs.is_rd !== e.is_rd || rs.ne !== e.ne)
        $display("FAIL rd_flags idx=%0d got we=%0b rd=%0b ne=%0b exp we=%0b rd=%0b ne=%0b",
                 idxs[k], rs.csr_we, rs.is_rd, rs.ne, e.csr_we, e.is_rd, e.ne); else n_pass++;
      n_checks++; if (rs.entry !== e.entry)
        $display("FAIL rd_entry idx=%0d got=%h exp=%h", idxs[k], rs.entry, e.entry); else n_pass++;
    end
  endtask

  task automatic test_invtlb();
    exec_t ex; resp_t rs, e; int lat;
    logic [88:0] key;
    key = mk_entry(1'b1, 19'h12345, 10'h001, 1'b0, 20'd0, 20'd0);
    exp_q.push_back(predict(3'd4, 5'd5, '0, 4'd0));
    run_op(3'd4, 5'd5, 10'h001, 19'h12345, '0, 4'd0, ex, rs, lat);
    e = exp_q.pop_front();
    n_checks++; if (ex.inv_valid !== 1'b1 || ex.inv_op !== 5'd5)
      $display("FAIL inv_strobe got v=%0b op=%0d exp v=1 op=5", ex.inv_valid, ex.inv_op); else n_pass++;
    n_checks++; if (ex.s1_asid !== 10'h001 || ex.s1_vppn !== 19'h12345)
      $display("FAIL inv_ports got asid=%0h vppn=%0h exp 1/12345", ex.s1_asid, ex.s1_vppn); else n_pass++;
    n_checks++; if (rs.csr_we !== e.csr_we || rs.ine !== e.ine)
      $display("FAIL inv_resp got we=%0b ine=%0b exp we=%0b ine=%0b", rs.csr_we, rs.ine, e.csr_we, e.ine); else n_pass++;

    exp_q.push_back(predict(3'd0, 5'd0, key, 4'd0));
    run_op(3'd0, 5'd0, 10'd0, 19'd0, key, 4'd0, ex, rs, lat);
    e = exp_q.pop_front();
    n_checks++; if (rs.ne !== e.ne || e.ne !== 1'b1)
      $display("FAIL srch_after_inv got ne=%0b exp ne=1", rs.ne); else n_pass++;

    exp_q.push_back(predict(3'd4, 5'd9, '0, 4'd0));
    run_op(3'd4, 5'd9, 10'h001, 19'h12345, '0, 4'd0, ex, rs, lat);
    e = exp_q.pop_front();
    n_checks++; if (ex.inv_valid !== 1'b0 || ex.we !== 1'b0)
      $display("FAIL inv_bad_strobe got inv=%0b we=%0b exp 0", ex.inv_valid, ex.we); else n_pass++;
    n_checks++; if (lat !== 2 || rs.ine !== e.ine || rs.csr_we !== e.csr_we)
      $display("FAIL inv_bad_ine got lat=%0d ine=%0b we=%0b exp lat=2 ine=%0b we=%0b",
               lat, rs.ine, rs.csr_we, e.ine, e.csr_we); else n_pass++;
  endtask

  task automatic test_fill();
    exec_t ex; resp_t rs, e; int lat;
    logic [3:0]  targets [4];
    logic [88:0] ef;
    targets = '{4'd3, 4'd10, 4'd15, 4'd0};
    foreach (targets[k]) begin
      ef = mk_entry(1'b1, 19'h40000 + 19'(k), 10'h020, 1'b0, 20'(k), 20'hF0F0F);
      wait_fc(targets[k]);
      exp_q.push_back(predict(3'd3, 5'd0, ef, 4'd0));
      run_op(3'd3, 5'd0, 10'd0, 19'd0, ef, 4'd0, ex, rs, lat);
      e = exp_q.pop_front();
      n_checks++; if (ex.we !== 1'b1 || ex.w_index !== targets[k])
        $display("FAIL fill_index got we=%0b idx=%0d exp we=1 idx=%0d", ex.we, ex.w_index, targets[k]); else n_pass++;
      n_checks++; if (ex.w_entry !== ef || rs.csr_we !== e.csr_we)
        $display("FAIL fill_data got entry=%h we=%0b exp entry=%h we=%0b", ex.w_entry, rs.csr_we, ef, e.csr_we); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int exp_we [6]    = '{1, 0, 0, 1, 0, 0};
    int exp_idx [6]   = '{1, 0, 0, 2, 0, 0};
    int exp_ready [6] = '{0, 0, 1, 0, 0, 1};
    int exp_done [6]  = '{0, 1, 0, 0, 1, 0};
    int n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_op = 3'd2; csr_index = 4'd1; csr_entry = mk_entry(1'b1, 19'h00111, 10'h002, 1'b1, 20'h1, 20'h2);
    req_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin
        csr_index = 4'd2;
        csr_entry = mk_entry(1'b1, 19'h00222, 10'h002, 1'b1, 20'h3, 20'h4);
      end
      if (c == 3) req_valid = 1'b0;
      n_checks++;
      if (int'(tlb_we) != exp_we[c] || int'(tlb_w_index) != exp_idx[c] ||
          int'(req_ready) != exp_ready[c] || int'(done) != exp_done[c])
        $display("FAIL b2b_cycle%0d got we=%0b idx=%0d rdy=%0b done=%0b exp we=%0d idx=%0d rdy=%0d done=%0d",
                 c, tlb_we, tlb_w_index, req_ready, done, exp_we[c], exp_idx[c], exp_ready[c], exp_done[c]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_op();
    logic [2:0] ops [2];
    int n, dones;
    ops = '{3'd2, 3'd4};
    foreach (ops[k]) begin
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      req_op = ops[k]; req_invop = 5'd5; req_inv_asid = 10'h002; req_inv_vppn = 19'h00111;
      csr_index = 4'd7; csr_entry = mk_entry(1'b1, 19'h0777, 10'h007, 1'b0, 20'h7, 20'h7);
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      n_checks++; if ((tlb_we | tlb_invtlb_valid) !== 1'b1)
        $display("FAIL rstmid_pre op=%0d got we=%0b inv=%0b exp one high", ops[k], tlb_we, tlb_invtlb_valid); else n_pass++;
      #1 resetn = 1'b0;
      #1;
      n_checks++; if (tlb_we !== 1'b0 || tlb_invtlb_valid !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0)
        $display("FAIL rstmid_async op=%0d got we=%0b inv=%0b rdy=%0b done=%0b exp 0/0/1/0",
                 ops[k], tlb_we, tlb_invtlb_valid, req_ready, done); else n_pass++;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      dones = 0;
      repeat (3) begin
        @(negedge clk);
        if (done || tlb_we || tlb_invtlb_valid || !req_ready) dones++;
      end
      n_checks++; if (dones !== 0)
        $display("FAIL rstmid_after op=%0d got activity_cycles=%0d exp=0", ops[k], dones); else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_invop = 5'd0;
    req_inv_asid = 10'd0; req_inv_vppn = 19'd0; csr_entry = '0; csr_index = 4'd0;
    repeat (3) @(negedge clk);
    test_reset();
    resetn = 1'b1;
    @(negedge clk);
    test_write_search();
    test_search_miss();
    test_read();
    test_invtlb();
    test_fill();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
